// File: rtl/dna_lock_checker.sv
// ============================================================================
//  Module      : dna_lock_checker
//  Description : Serially reads a device ID and compares it against a set of
//                expected IDs, reporting the lowest-numbered matching slot.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dna_lock_checker #(
    parameter  int ID_WIDTH    = 57,
    parameter  int NUM_KEYS    = 4,
    parameter  int START_DELAY = 32,
    localparam int IDX_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [NUM_KEYS*ID_WIDTH-1:0] keys,
    input  logic [NUM_KEYS-1:0]          key_valid,
    output logic                         id_read,
    output logic                         id_shift,
    input  logic                         id_dout,
    output logic                         busy,
    output logic                         check_done,
    output logic                         match,
    output logic [IDX_W-1:0]             match_idx,
    output logic [ID_WIDTH-1:0]          id_value
);

    localparam int c_BW = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                r_state,     w_next;
    logic [7:0]            r_delayCnt,  w_delayCnt;
    logic [c_BW-1:0]       r_bitCnt,    w_bitCnt;
    logic [NUM_KEYS-1:0]   r_mismatch,  w_mismatch;
    logic                  r_idRead,    w_idRead;
    logic                  r_idShift,   w_idShift;
    logic                  r_busy,      w_busy;
    logic                  r_checkDone, w_checkDone;
    logic                  r_match,     w_match;
    logic [IDX_W-1:0]      r_matchIdx,  w_matchIdx;
    logic [ID_WIDTH-1:0]   r_idValue,   w_idValue;

    logic [c_BW-1:0]       w_bitPos;
    logic [NUM_KEYS-1:0]   w_bitMis;
    logic [NUM_KEYS-1:0]   w_hit;
    logic [IDX_W-1:0]      w_hitIdx;

    // The ID arrives MSB first, so cycle n lines up with key bit ID_WIDTH-1-n.
    assign w_bitPos = c_BW'(ID_WIDTH - 1) - r_bitCnt;

    generate
        for (genvar k = 0; k < NUM_KEYS; k++) begin : g_slot
            logic [ID_WIDTH-1:0] w_key;
            assign w_key       = keys[k*ID_WIDTH +: ID_WIDTH];
            assign w_bitMis[k] = id_dout ^ w_key[w_bitPos];
            assign w_hit[k]    = key_valid[k] & ~(r_mismatch[k] | w_bitMis[k]);
        end
    endgenerate

    always_comb begin
        w_hitIdx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_hitIdx = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_delayCnt  <= '0;
            r_bitCnt    <= '0;
            r_mismatch  <= '0;
            r_idRead    <= 1'b0;
            r_idShift   <= 1'b0;
            r_busy      <= 1'b0;
            r_checkDone <= 1'b0;
            r_match     <= 1'b0;
            r_matchIdx  <= '0;
            r_idValue   <= '0;
        end else begin
            r_state     <= w_next;
            r_delayCnt  <= w_delayCnt;
            r_bitCnt    <= w_bitCnt;
            r_mismatch  <= w_mismatch;
            r_idRead    <= w_idRead;
            r_idShift   <= w_idShift;
            r_busy      <= w_busy;
            r_checkDone <= w_checkDone;
            r_match     <= w_match;
            r_matchIdx  <= w_matchIdx;
            r_idValue   <= w_idValue;
        end
    end

    // Strobes are computed one state ahead so they are registered in the
    // cycle their state is active.
    always_comb begin
        w_next      = r_state;
        w_delayCnt  = r_delayCnt;
        w_bitCnt    = r_bitCnt;
        w_mismatch  = r_mismatch;
        w_idRead    = 1'b0;
        w_idShift   = 1'b0;
        w_busy      = r_busy;
        w_checkDone = r_checkDone;
        w_match     = r_match;
        w_matchIdx  = r_matchIdx;
        w_idValue   = r_idValue;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next      = ST_WAIT;
                    w_delayCnt  = 8'(START_DELAY - 1);
                    w_busy      = 1'b1;
                    w_checkDone = 1'b0;
                    w_match     = 1'b0;
                    w_matchIdx  = '0;
                    w_idValue   = '0;
                end
            end
            ST_WAIT: begin
                if (r_delayCnt == 8'd0) begin
                    w_next   = ST_READ;
                    w_idRead = 1'b1;
                end else begin
                    w_delayCnt = r_delayCnt - 8'd1;
                end
            end
            ST_READ: begin
                w_next     = ST_SHIFT;
                w_bitCnt   = '0;
                w_mismatch = '0;
                w_idShift  = 1'b1;
            end
            ST_SHIFT: begin
                w_idValue  = {r_idValue[ID_WIDTH-2:0], id_dout};
                w_mismatch = r_mismatch | w_bitMis;
                if (r_bitCnt == c_BW'(ID_WIDTH - 1)) begin
                    w_next      = ST_DONE;
                    w_busy      = 1'b0;
                    w_checkDone = 1'b1;
                    w_match     = |w_hit;
                    w_matchIdx  = w_hitIdx;
                end else begin
                    w_bitCnt  = r_bitCnt + c_BW'(1);
                    w_idShift = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign id_read    = r_idRead;
    assign id_shift   = r_idShift;
    assign busy       = r_busy;
    assign check_done = r_checkDone;
    assign match      = r_match;
    assign match_idx  = r_matchIdx;
    assign id_value   = r_idValue;

endmodule

`default_nettype wire

// File: tb/tb_dna_lock_checker.sv
// ============================================================================
//  Module      : tb_dna_lock_checker
//  Description : Directed self-checking bench for dna_lock_checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dna_lock_checker;

    localparam int ID_WIDTH    = 57;
    localparam int NUM_KEYS    = 4;
    localparam int START_DELAY = 32;
    localparam int IDX_W       = 2;
    localparam logic [ID_WIDTH-1:0] c_ID    = 57'h03431c21141b01c;
    localparam logic [ID_WIDTH-1:0] c_OTHER = 57'h1f0e0d0c0b0a090;

    logic                         clk = 1'b0;
    logic                         reset_n = 1'b0;
    logic                         start = 1'b0;
    logic [NUM_KEYS*ID_WIDTH-1:0] keys = '0;
    logic [NUM_KEYS-1:0]          key_valid = '0;
    logic                         id_read;
    logic                         id_shift;
    logic                         id_dout;
    logic                         busy;
    logic                         check_done;
    logic                         match;
    logic [IDX_W-1:0]             match_idx;
    logic [ID_WIDTH-1:0]          id_value;

    logic [ID_WIDTH-1:0] modelId = '0;
    logic [ID_WIDTH-1:0] r_modelSr = '0;
    int checks = 0;
    int errors = 0;

    dna_lock_checker #(
        .ID_WIDTH    (ID_WIDTH),
        .NUM_KEYS    (NUM_KEYS),
        .START_DELAY (START_DELAY)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .keys       (keys),
        .key_valid  (key_valid),
        .id_read    (id_read),
        .id_shift   (id_shift),
        .id_dout    (id_dout),
        .busy       (busy),
        .check_done (check_done),
        .match      (match),
        .match_idx  (match_idx),
        .id_value   (id_value)
    );

    always #5 clk = ~clk;

    // ID port model: load on read, shift left on shift, MSB presented.
    always @(posedge clk) begin
        if (id_read)       r_modelSr <= modelId;
        else if (id_shift) r_modelSr <= r_modelSr << 1;
    end
    assign id_dout = r_modelSr[ID_WIDTH-1];

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            assert (!(id_read && id_shift)) else $error("read/shift overlap");
            assert (!(busy && check_done)) else $error("busy with done");
            checkVal("rd_sh_excl", {63'd0, id_read & id_shift}, 64'd0);
            checkVal("busy_done_excl", {63'd0, busy & check_done}, 64'd0);
        end
    end

    // Cycle 1 is the edge that samples start; pulseAt re-asserts start for
    // one edge at the given cycle.
    task automatic runCheck(input int pulseAt, output int readCyc, output int readCnt,
                            output int shiftCnt, output int doneCyc, output logic doneAt1);
        readCyc = 0; readCnt = 0; shiftCnt = 0; doneCyc = 0; doneAt1 = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 200 && doneCyc == 0; c++) begin
            @(negedge clk);
            start = (c == pulseAt);
            if (c == 1) doneAt1 = check_done;
            if (id_read) begin
                readCnt++;
                if (readCyc == 0) readCyc = c;
            end
            if (id_shift) shiftCnt++;
            if (check_done) doneCyc = c;
            if (doneCyc == 0) @(posedge clk);
        end
        start = 1'b0;
    endtask

    task automatic checkTiming(input string tag, input int pulseAt);
        int rc, rn, sc, dc;
        logic d1;
        runCheck(pulseAt, rc, rn, sc, dc, d1);
        checkVal({tag, "_read_cyc"}, 64'(rc), 64'd33);
        checkVal({tag, "_read_cnt"}, 64'(rn), 64'd1);
        checkVal({tag, "_shift_cnt"}, 64'(sc), 64'd57);
        checkVal({tag, "_done_cyc"}, 64'(dc), 64'd91);
        checkVal({tag, "_done_cleared"}, {63'd0, d1}, 64'd0);
        checkVal({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        keys = '0;
        keys[2*ID_WIDTH +: ID_WIDTH] = c_ID;
        key_valid = 4'b0100;
        modelId = c_ID;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rst_busy", {63'd0, busy}, 64'd0);
        checkVal("rst_done", {63'd0, check_done}, 64'd0);
        checkVal("rst_outs", {58'd0, id_read, id_shift, match, match_idx, 1'b0}, 64'd0);
        checkVal("rst_idval", 64'(id_value), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checkVal("idle_no_selfstart", {62'd0, busy, id_read}, 64'd0);

        // Single matching slot
        checkTiming("m2", 0);
        checkVal("m2_match", {63'd0, match}, 64'd1);
        checkVal("m2_idx", 64'(match_idx), 64'd2);
        checkVal("m2_idval", 64'(id_value), 64'(c_ID));
        checkVal("m2_done", {63'd0, check_done}, 64'd1);

        // LSB flipped: no match; started from DONE
        modelId = c_ID ^ 57'd1;
        checkTiming("lsb", 0);
        checkVal("lsb_match", {63'd0, match}, 64'd0);
        checkVal("lsb_idx", 64'(match_idx), 64'd0);
        checkVal("lsb_done", {63'd0, check_done}, 64'd1);
        checkVal("lsb_idval", 64'(id_value), 64'h03431c21141b01d);

        // Duplicates in 1 and 3; slot 0 also holds the ID but is disabled
        modelId = c_ID;
        keys[0*ID_WIDTH +: ID_WIDTH] = c_ID;
        keys[1*ID_WIDTH +: ID_WIDTH] = c_ID;
        keys[2*ID_WIDTH +: ID_WIDTH] = c_OTHER;
        keys[3*ID_WIDTH +: ID_WIDTH] = c_ID;
        key_valid = 4'b1010;
        checkTiming("dup", 0);
        checkVal("dup_match", {63'd0, match}, 64'd1);
        checkVal("dup_idx", 64'(match_idx), 64'd1);

        key_valid = 4'b0000;
        checkTiming("none", 0);
        checkVal("none_match", {63'd0, match}, 64'd0);
        checkVal("none_idx", 64'(match_idx), 64'd0);
        checkVal("none_done", {63'd0, check_done}, 64'd1);

        // Start pulsed mid-SHIFT is ignored
        key_valid = 4'b1000;
        checkTiming("restart", 60);
        checkVal("restart_match", {63'd0, match}, 64'd1);
        checkVal("restart_idx", 64'(match_idx), 64'd3);
        repeat (3) @(negedge clk);
        checkVal("restart_hold", {62'd0, check_done, busy}, 64'd2);

        // Reset during SHIFT cycle 20 (cycle 34 is SHIFT cycle 0)
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c < 54; c++) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        checkVal("pre_abort_shift", {63'd0, id_shift}, 64'd1);
        reset_n = 1'b0;
        #1;
        checkVal("abort_outs", {59'd0, id_read, id_shift, busy, check_done, match}, 64'd0);
        checkVal("abort_idx", 64'(match_idx), 64'd0);
        checkVal("abort_idval", 64'(id_value), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        checkVal("abort_idle", {61'd0, busy, id_read, id_shift}, 64'd0);

        key_valid = 4'b0010;
        checkTiming("post", 0);
        checkVal("post_match", {63'd0, match}, 64'd1);
        checkVal("post_idx", 64'(match_idx), 64'd1);
        checkVal("post_idval", 64'(id_value), 64'(c_ID));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
